// File: rtl/ps2_transmitter_if.sv
// rtl/ps2_transmitter_if.sv - command and PS/2 pin signals between host logic and the PS/2 transmitter
interface ps2_transmitter_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       ps2_clk_in;
  logic       ps2_dat_in;
  logic       ps2_clk_oe;
  logic       ps2_dat_oe;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_error;

  modport master (
    output tx_data, tx_start, ps2_clk_in, ps2_dat_in,
    input  ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error
  );

  modport slave (
    input  tx_data, tx_start, ps2_clk_in, ps2_dat_in,
    output ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error
  );
endinterface

// File: rtl/ps2_transmitter.sv
// rtl/ps2_transmitter.sv - host-to-device PS/2 byte transmitter driving open-collector enables
module ps2_transmitter #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int START_TIMEOUT  = 750000,
  parameter int PACKET_TIMEOUT = 100000,
  parameter int FILTER_LEN     = 8
) (
  input logic clock,
  input logic reset,
  ps2_transmitter_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    REQ,
    WAIT_CLK,
    SHIFT,
    ACK,
    WAIT_IDLE,
    ERROR
  } state_t;

  localparam logic [19:0] INHIBIT_LAST = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] START_LAST   = 20'(START_TIMEOUT - 1);
  localparam logic [19:0] PACKET_LAST  = 20'(PACKET_TIMEOUT - 1);
  localparam logic [7:0]  FILTER_LAST  = 8'(FILTER_LEN - 1);

  state_t      state;
  logic        clk_s1, clk_s2, dat_s1, dat_s2;
  logic        clk_f;
  logic [7:0]  flt_cnt;
  logic        fall;
  logic [19:0] cnt;
  logic [19:0] cnt_inc;
  logic [3:0]  idx;
  logic [7:0]  data;
  logic        par;
  logic        clk_oe, dat_oe, busy, done, error;
  logic        pkt_expired;
  logic        to_error;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= bus.ps2_clk_in;
      clk_s2 <= clk_s1;
      dat_s1 <= bus.ps2_dat_in;
      dat_s2 <= dat_s1;
    end
  end

  // A new CLK level is accepted only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_f   <= 1'b1;
      flt_cnt <= 8'd0;
      fall    <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s2 == clk_f) begin
        flt_cnt <= 8'd0;
      end else if (flt_cnt == FILTER_LAST) begin
        clk_f   <= clk_s2;
        flt_cnt <= 8'd0;
        fall    <= ~clk_s2;
      end else begin
        flt_cnt <= flt_cnt + 8'd1;
      end
    end
  end

  assign cnt_inc     = (cnt == 20'hFFFFF) ? cnt : cnt + 20'd1;
  assign pkt_expired = (cnt == PACKET_LAST);

  // Timeouts take priority over a fall strobe arriving in the same cycle.
  always_comb begin
    to_error = 1'b0;
    case (state)
      WAIT_CLK:         to_error = (cnt == START_LAST);
      SHIFT, WAIT_IDLE: to_error = pkt_expired;
      ACK:              to_error = pkt_expired || (fall && dat_s2);
      default:          to_error = 1'b0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      clk_oe <= 1'b0;
      dat_oe <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      cnt    <= 20'd0;
      idx    <= 4'd0;
      data   <= 8'd0;
      par    <= 1'b0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      if (to_error) begin
        clk_oe <= 1'b0;
        dat_oe <= 1'b0;
        busy   <= 1'b0;
        error  <= 1'b1;
        state  <= ERROR;
      end else begin
        case (state)
          IDLE: begin
            clk_oe <= 1'b0;
            dat_oe <= 1'b0;
            // a start landing on the completion pulse cycle is dropped
            if (bus.tx_start && !done && !error) begin
              data   <= bus.tx_data;
              par    <= ~^bus.tx_data;
              busy   <= 1'b1;
              cnt    <= 20'd0;
              clk_oe <= 1'b1;
              state  <= INHIBIT;
            end
          end
          INHIBIT: begin
            clk_oe <= 1'b1;
            if (cnt == INHIBIT_LAST) begin
              dat_oe <= 1'b1;
              state  <= REQ;
            end else begin
              cnt <= cnt_inc;
            end
          end
          REQ: begin
            clk_oe <= 1'b0;
            cnt    <= 20'd0;
            idx    <= 4'd0;
            state  <= WAIT_CLK;
          end
          WAIT_CLK: begin
            if (fall) begin
              dat_oe <= ~data[0];
              idx    <= 4'd1;
              cnt    <= 20'd0;
              state  <= SHIFT;
            end else begin
              cnt <= cnt_inc;
            end
          end
          SHIFT: begin
            cnt <= cnt_inc;
            if (fall) begin
              idx <= idx + 4'd1;
              case (idx)
                4'd8: dat_oe <= ~par;
                4'd9: begin
                  dat_oe <= 1'b0;
                  state  <= ACK;
                end
                default: dat_oe <= ~data[idx[2:0]];
              endcase
            end
          end
          ACK: begin
            cnt <= cnt_inc;
            if (fall) begin
              state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            cnt <= cnt_inc;
            if (clk_s2 && dat_s2) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
          ERROR: begin
            clk_oe <= 1'b0;
            dat_oe <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign bus.ps2_clk_oe = clk_oe;
  assign bus.ps2_dat_oe = dat_oe;
  assign bus.tx_busy    = busy;
  assign bus.tx_done    = done;
  assign bus.tx_error   = error;

endmodule

// File: tb/tb_ps2_transmitter.sv
// tb/tb_ps2_transmitter.sv - directed bench for ps2_transmitter with a clocking PS/2 device model
module tb_ps2_transmitter;
  localparam int INHIBIT   = 50;
  localparam int START_TO  = 2000;
  localparam int PACKET_TO = 1500;
  localparam int FILT      = 8;
  localparam int HALF      = 40;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic device_clk = 1'b1;
  logic device_dat = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;

  ps2_transmitter_if bus();

  assign bus.ps2_clk_in = ~bus.ps2_clk_oe & device_clk;
  assign bus.ps2_dat_in = ~bus.ps2_dat_oe & device_dat;

  ps2_transmitter #(
    .INHIBIT_CYCLES(INHIBIT),
    .START_TIMEOUT (START_TO),
    .PACKET_TIMEOUT(PACKET_TO),
    .FILTER_LEN    (FILT)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #10 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (bus.tx_done === 1'b1) done_cnt <= done_cnt + 1;
    if (bus.tx_error === 1'b1) err_cnt <= err_cnt + 1;
  end

  task automatic pulse_start(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_start = 1'b1;
    @(negedge clock);
    bus.tx_start = 1'b0;
  endtask

  // Device side: start bit is read when the host releases CLK, later bits on each rising edge.
  task automatic device_run(input int n_falls, input logic ack_low, input int glitch_after,
                            output logic [10:0] bits, output int fall_cyc);
    int n;
    bits = 11'd0;
    fall_cyc = cyc;
    n = 0;
    while (!(bus.ps2_clk_in === 1'b1 && bus.ps2_dat_in === 1'b0) && n < 400) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (n >= 400) begin
      errors++;
      $display("FAIL device_request: no host request seen within %0d cycles", n);
      return;
    end
    bits[0] = bus.ps2_dat_in;
    repeat (HALF) @(negedge clock);
    for (int f = 1; f <= n_falls; f++) begin
      device_clk = 1'b0;
      if (f == 1) fall_cyc = cyc;
      if (f == 11 && ack_low) device_dat = 1'b0;
      repeat (HALF) @(negedge clock);
      if (f <= 10) bits[f] = bus.ps2_dat_in;
      device_clk = 1'b1;
      if (f == 11) device_dat = 1'b1;
      if (f == glitch_after) begin
        repeat (10) @(negedge clock);
        device_clk = 1'b0;
        repeat (3) @(negedge clock);
        device_clk = 1'b1;
        repeat (HALF - 13) @(negedge clock);
      end else begin
        repeat (HALF) @(negedge clock);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if ({bus.ps2_clk_oe, bus.ps2_dat_oe} !== 2'b00) begin
      errors++;
      $display("FAIL reset_enables: got %b expected 00", {bus.ps2_clk_oe, bus.ps2_dat_oe});
    end
    checks++;
    if ({bus.tx_busy, bus.tx_done, bus.tx_error} !== 3'b000) begin
      errors++;
      $display("FAIL reset_status: got %b expected 000", {bus.tx_busy, bus.tx_done, bus.tx_error});
    end
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checks++;
    if ({bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_busy} !== 3'b000) begin
      errors++;
      $display("FAIL idle_after_reset: got %b expected 000", {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_busy});
    end
  endtask

  task automatic run_frame(input string name, input logic [7:0] d, input logic [10:0] exp_bits,
                           input int glitch_after);
    int d0, e0, n, fc;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(d);
    checks++;
    if (bus.tx_busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_rise: got %b expected 1", name, bus.tx_busy);
    end
    n = 0;
    while (bus.ps2_dat_oe === 1'b0 && n < INHIBIT + 20) begin
      if (bus.ps2_clk_oe === 1'b1) n++;
      @(negedge clock);
    end
    checks++;
    if (n !== INHIBIT || bus.ps2_clk_oe !== 1'b1) begin
      errors++;
      $display("FAIL %s inhibit: got %0d cycles clk_oe=%b expected %0d cycles clk_oe=1",
               name, n, bus.ps2_clk_oe, INHIBIT);
    end
    device_run(11, 1'b1, glitch_after, bits, fc);
    checks++;
    if (bits !== exp_bits) begin
      errors++;
      $display("FAIL %s frame_bits: got %b expected %b", name, bits, exp_bits);
    end
    n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL %s completion: got done=%0d error=%0d expected done=1 error=0",
               name, done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if ({bus.tx_busy, bus.ps2_clk_oe, bus.ps2_dat_oe} !== 3'b000) begin
      errors++;
      $display("FAIL %s idle_after: got busy/clk_oe/dat_oe=%b expected 000",
               name, {bus.tx_busy, bus.ps2_clk_oe, bus.ps2_dat_oe});
    end
  endtask

  task automatic test_start_timeout();
    int d0, e0, n, k;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(8'hA5);
    n = 0;
    while (bus.ps2_dat_oe !== 1'b1 && n < INHIBIT + 20) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checks++;
    if (bus.ps2_clk_oe !== 1'b0) begin
      errors++;
      $display("FAIL start_to_release: got clk_oe=%b expected 0", bus.ps2_clk_oe);
    end
    k = 0;
    while (bus.tx_error !== 1'b1 && k < START_TO + 50) begin
      @(negedge clock);
      k++;
    end
    checks++;
    if (k !== START_TO) begin
      errors++;
      $display("FAIL start_timeout_time: got %0d cycles expected %0d", k, START_TO);
    end
    checks++;
    if ({bus.ps2_clk_oe, bus.ps2_dat_oe} !== 2'b00) begin
      errors++;
      $display("FAIL start_timeout_lines: got %b expected 00", {bus.ps2_clk_oe, bus.ps2_dat_oe});
    end
    repeat (3) @(negedge clock);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1 || bus.tx_busy !== 1'b0) begin
      errors++;
      $display("FAIL start_timeout_pulses: got done=%0d error=%0d busy=%b expected 0 1 0",
               done_cnt - d0, err_cnt - e0, bus.tx_busy);
    end
  endtask

  task automatic test_missing_ack();
    int d0, e0, n, fc;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(8'h3C);
    device_run(11, 1'b0, 0, bits, fc);
    n = 0;
    while (err_cnt == e0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    @(negedge clock);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
      errors++;
      $display("FAIL missing_ack: got done=%0d error=%0d expected done=0 error=1",
               done_cnt - d0, err_cnt - e0);
    end
    checks++;
    if ({bus.tx_busy, bus.ps2_clk_oe, bus.ps2_dat_oe} !== 3'b000) begin
      errors++;
      $display("FAIL missing_ack_lines: got busy/clk_oe/dat_oe=%b expected 000",
               {bus.tx_busy, bus.ps2_clk_oe, bus.ps2_dat_oe});
    end
  endtask

  task automatic test_packet_timeout();
    int d0, e0, n, fc, ec, delta;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(8'h55);
    device_run(5, 1'b1, 0, bits, fc);
    n = 0;
    while (bus.tx_error !== 1'b1 && n < PACKET_TO + 100) begin
      @(negedge clock);
      n++;
    end
    ec = cyc;
    delta = ec - fc;
    // first-fall latency through sync and filter is 11 cycles
    checks++;
    if (delta < PACKET_TO + 9 || delta > PACKET_TO + 13) begin
      errors++;
      $display("FAIL packet_timeout_time: got %0d cycles expected %0d", delta, PACKET_TO + 11);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1 ||
        {bus.tx_busy, bus.ps2_clk_oe, bus.ps2_dat_oe} !== 3'b000) begin
      errors++;
      $display("FAIL packet_timeout_state: got done=%0d error=%0d busy/oe=%b expected 0 1 000",
               done_cnt - d0, err_cnt - e0, {bus.tx_busy, bus.ps2_clk_oe, bus.ps2_dat_oe});
    end
  endtask

  task automatic test_reset_mid_shift();
    int d0, e0, fc;
    logic [10:0] bits;
    pulse_start(8'hF0);
    device_run(4, 1'b1, 0, bits, fc);
    checks++;
    if ({bus.tx_busy, bus.ps2_dat_oe} !== 2'b11) begin
      errors++;
      $display("FAIL mid_shift_state: got busy/dat_oe=%b expected 11", {bus.tx_busy, bus.ps2_dat_oe});
    end
    d0 = done_cnt;
    e0 = err_cnt;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_busy} !== 3'b000) begin
      errors++;
      $display("FAIL reset_mid_shift: got clk_oe/dat_oe/busy=%b expected 000",
               {bus.ps2_clk_oe, bus.ps2_dat_oe, bus.tx_busy});
    end
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    checks++;
    if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0) begin
      errors++;
      $display("FAIL reset_no_pulse: got done=%0d error=%0d expected 0 0", done_cnt - d0, err_cnt - e0);
    end
    run_frame("after_reset", 8'h00, 11'b11000000000, 0);
  endtask

  task automatic test_back_to_back();
    int d0, e0, fc;
    logic [10:0] bits;
    d0 = done_cnt;
    e0 = err_cnt;
    pulse_start(8'h01);
    repeat (5) @(negedge clock);
    pulse_start(8'hFF);
    fork
      device_run(11, 1'b1, 0, bits, fc);
      begin
        int n;
        n = 0;
        while (bus.tx_done !== 1'b1 && n < 3000) begin
          @(negedge clock);
          n++;
        end
        pulse_start(8'h81);
        checks++;
        if (bus.tx_busy !== 1'b0) begin
          errors++;
          $display("FAIL start_on_done: got busy=%b expected 0", bus.tx_busy);
        end
      end
    join
    checks++;
    if (bits !== 11'b10000000010) begin
      errors++;
      $display("FAIL back_to_back_bits: got %b expected %b", bits, 11'b10000000010);
    end
    repeat (100) @(negedge clock);
    checks++;
    if (done_cnt - d0 !== 1 || err_cnt - e0 !== 0 ||
        {bus.tx_busy, bus.ps2_clk_oe} !== 2'b00) begin
      errors++;
      $display("FAIL back_to_back_count: got done=%0d error=%0d busy/clk_oe=%b expected 1 0 00",
               done_cnt - d0, err_cnt - e0, {bus.tx_busy, bus.ps2_clk_oe});
    end
  endtask

  initial begin
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    @(negedge clock);
    test_reset();
    run_frame("ed", 8'hED, 11'b11111011010, 0);
    run_frame("x01", 8'h01, 11'b10000000010, 0);
    run_frame("x00", 8'h00, 11'b11000000000, 0);
    run_frame("xff", 8'hFF, 11'b11111111110, 0);
    test_start_timeout();
    test_missing_ack();
    test_packet_timeout();
    run_frame("glitch", 8'hED, 11'b11111011010, 4);
    test_reset_mid_shift();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_transmitter.md
Name: ps2_transmitter

Overview:
Host-to-device PS/2 transmitter. It sends one command byte to the keyboard, such as an LED-set command (ED) or a reset command (FF). It is the send-side counterpart of the PS/2 receive path on the same PS2_CLK/PS2_DAT pins. It drives the open-collector lines through output-enable signals: the top level assigns the pin to 0 when the enable is 1, otherwise z. It runs on the 50 MHz clock.

Parameters:
INHIBIT_CYCLES, 5000, clock cycles CLK is held low before the request (100 us at 50 MHz)
START_TIMEOUT, 750000, maximum cycles from CLK release to the first device falling edge (15 ms)
PACKET_TIMEOUT, 100000, maximum cycles from the first falling edge to the ACK edge (2 ms)
FILTER_LEN, 8, consecutive equal synchronized samples required to accept a new CLK level

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-high reset
tx_data  in  8  byte to send; latched when tx_start is accepted
tx_start  in  1  single-cycle request; ignored while tx_busy=1
ps2_clk_in  in  1  raw PS2_CLK pin level
ps2_dat_in  in  1  raw PS2_DAT pin level
ps2_clk_oe  out  1  1 = pull PS2_CLK low
ps2_dat_oe  out  1  1 = pull PS2_DAT low
tx_busy  out  1  transfer in progress; the receive path ignores data while this is 1
tx_done  out  1  one-cycle pulse: byte sent and device ACK seen
tx_error  out  1  one-cycle pulse: timeout or missing ACK

Behaviour:
- Reset (asynchronous):
  - state=IDLE; ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error all 0.
  - A reset in the middle of a transfer releases both lines immediately, with no completion pulse.
- Input conditioning:
  - Both pins pass through a 2-FF synchronizer.
  - CLK then goes through a FILTER_LEN glitch filter.
  - A falling edge is a filtered transition 1->0, producing a one-cycle fall strobe.
- Parity: odd, i.e. par = ~^tx_data latched.
- States:
  - IDLE: lines released. On tx_start: latch the byte and parity, tx_busy<=1, clear the counter, go to INHIBIT. tx_busy rises the cycle after tx_start.
  - INHIBIT: ps2_clk_oe=1. On counter = INHIBIT_CYCLES-1, set ps2_dat_oe=1 (start bit) and go to REQ.
  - REQ (exactly 1 cycle): both enables = 1. Next cycle ps2_clk_oe<=0, clear the counter, bit index=0, go to WAIT_CLK.
  - WAIT_CLK: ps2_dat_oe stays 1. On fall: drive D0 (ps2_dat_oe<=~data[0]), index=1, clear the counter, go to SHIFT. If the counter reaches START_TIMEOUT, go to ERROR.
  - SHIFT: on each fall, with n = index:
    - n=1..7: ps2_dat_oe<=~data[n].
    - n=8: ps2_dat_oe<=~par.
    - n=9: ps2_dat_oe<=0 (stop bit, line released), go to ACK.
    - The index increments on each fall.
  - ACK: on the next fall, sample the synchronized DAT. 0 goes to WAIT_IDLE; 1 goes to ERROR.
  - The PACKET_TIMEOUT counter runs through SHIFT, ACK and WAIT_IDLE; expiry goes to ERROR.
  - WAIT_IDLE: when synchronized CLK=1 and DAT=1, pulse tx_done, tx_busy<=0, go to IDLE.
  - ERROR: both enables 0, pulse tx_error, tx_busy<=0, go to IDLE. The error path takes 1 cycle.
- Output timing: enables change only in the cycle after the fall strobe. Worst-case latency from a device edge is 2 sync + FILTER_LEN + 1 cycles, well inside the 5 us setup window.
- Counters: 20-bit, saturating; they never wrap.
- Simultaneous events:
  - tx_start in the same cycle that tx_done or tx_error is asserted is ignored.
  - A fall strobe in the same cycle as timeout expiry: the timeout wins.

Test Plan:
- tx_data=ED, device model clocks at 12.5 kHz with ACK. Required:
  - CLK low for 5000 cycles, then DAT low.
  - Bits seen on the device's rising edges: 0, 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - tx_done pulses once after the lines idle; tx_busy=0.
- tx_data=01 -> parity bit 0. tx_data=00 -> parity 1. tx_data=FF -> parity 1. All three complete with tx_done.
- Device never clocks -> tx_error at exactly START_TIMEOUT cycles after CLK release; both enables 0; no tx_done.
- Device leaves DAT high on the 11th falling edge -> tx_error; lines released.
- Device stops after 5 edges -> tx_error at PACKET_TIMEOUT.
- Two further checks:
  - A 3-cycle glitch on CLK during SHIFT -> no bit advance.
  - Reset asserted mid-SHIFT -> both enables 0 within the same cycle, tx_busy=0, and the next tx_start works normally.
- A second tx_start while busy is ignored: only one frame is transmitted.
